// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle M-extension unit (mulhu/divu/remu).
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [4:0] ALU_MULHU = 5'b01111;
    localparam logic [4:0] ALU_DIVU  = 5'b10000;
    localparam logic [4:0] ALU_REMU  = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shift/subtract/add datapath shared by restoring divide and shift-add multiply.
// Outputs are the post-step values so the sequencer can capture them on the last iteration.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_mul_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic [XLEN-1:0] prod_hi_o
);

    // hi: remainder / accumulator, lo: quotient / multiplier, opnd: divisor / multiplicand
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q;

    logic [XLEN:0]   shifted_rem;
    logic [XLEN+1:0] trial;
    logic            no_borrow;
    logic [XLEN-1:0] div_hi_nxt, div_lo_nxt;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;

    always_comb begin
        shifted_rem = {hi_q, lo_q[XLEN-1]};
        // One spare bit so the borrow is visible even when the shifted remainder uses bit XLEN
        trial       = {1'b0, shifted_rem} - {2'b00, opnd_q};
        no_borrow   = ~trial[XLEN+1];
        div_hi_nxt  = no_borrow ? trial[XLEN-1:0] : shifted_rem[XLEN-1:0];
        div_lo_nxt  = {lo_q[XLEN-2:0], no_borrow};

        mul_sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
        mul_hi_nxt  = mul_sum[XLEN:1];
        mul_lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};

        hi_d        = is_mul_i ? mul_hi_nxt : div_hi_nxt;
        lo_d        = is_mul_i ? mul_lo_nxt : div_lo_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= a_i;
            opnd_q <= b_i;
        end else if (step_i) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign quotient_o  = div_lo_nxt;
    assign remainder_o = div_hi_nxt;
    assign prod_hi_o   = mul_hi_nxt;

endmodule

// File: rtl/mdu_sequencer.sv
// Execute-stage MDU controller: FSM, iteration counter, pipeline stall and registered result.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             launch;
    logic             div_by_zero;
    logic             core_load, core_step;
    logic [XLEN-1:0]  core_quo, core_rem, core_prod_hi;

    mdu_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (core_load),
        .step_i      (core_step),
        .is_mul_i    (op_q == ALU_MULHU),
        .a_i         (a_i),
        .b_i         (b_i),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .prod_hi_o   (core_prod_hi)
    );

    always_comb begin
        launch      = (state_q == IDLE) & start_i & is_mdu_op(op_i) & ~flush_i;
        div_by_zero = (op_i != ALU_MULHU) & (b_i == '0);

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        op_d  = op_i;
                        cnt_d = '0;
                        if (div_by_zero) begin
                            state_d  = DONE;
                            result_d = (op_i == ALU_DIVU) ? '1 : a_i;
                        end else begin
                            state_d   = CALC;
                            core_load = 1'b1;
                        end
                    end
                end
                CALC: begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    // Result is captured from the core's final-step values on the same edge
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        case (op_q)
                            ALU_DIVU: result_d = core_quo;
                            ALU_REMU: result_d = core_rem;
                            default:  result_d = core_prod_hi;
                        endcase
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = rst_n & (((state_q == CALC) & ~flush_i) | launch);
    assign done_o   = (state_q == DONE) & ~flush_i;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table, random ops vs. a model, and corner sequences.
module tb_mdu_sequencer;

    localparam logic [4:0] OP_MULHU = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_REMU  = 5'b10001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [4:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    mdu_sequencer #(
        .XLEN (32),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    // Drives one op starting this cycle; start_i stays high, caller decides when to drop it.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        bit got;
        logic [31:0] want;
        got = 1'b0;
        sb.push_back(exp);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        for (int cyc = 0; cyc <= lat + 3 && !got; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                chk({tag, " latency"}, cyc, lat);
                chk({tag, " stall_in_done"}, {31'b0, stall_o}, 32'd0);
                want = sb.pop_front();
                chk({tag, " result"}, result_o, want);
            end else begin
                chk({tag, " stall"}, {31'b0, stall_o}, 32'd1);
            end
            @(posedge clk);
            #1;
            a_i = $urandom;
            b_i = $urandom;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done_o expected done at cycle %0d", tag, lat);
            void'(sb.pop_front());
        end
    endtask

    task automatic idle_check(input string tag, input logic [31:0] hold);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle_stall"}, {31'b0, stall_o}, 32'd0);
        chk({tag, " idle_done"}, {31'b0, done_o}, 32'd0);
        chk({tag, " hold"}, result_o, hold);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          bad;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{"divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'd14,        33};
        tbl[1] = '{"remu_100_7",   OP_REMU,  32'd100,       32'd7,         32'd2,         33};
        tbl[2] = '{"remu_max_1",   OP_REMU,  32'hFFFF_FFFF, 32'd1,         32'd0,         33};
        tbl[3] = '{"divu_max_1",   OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        tbl[4] = '{"mulhu_max",    OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[5] = '{"mulhu_msb_2",  OP_MULHU, 32'h8000_0000, 32'd2,         32'd1,         33};
        tbl[6] = '{"divu_by_zero", OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        tbl[7] = '{"remu_by_zero", OP_REMU,  32'd5,         32'd0,         32'd5,         1};
        tbl[8] = '{"divu_max_max", OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33};
        tbl[9] = '{"remu_small",   OP_REMU,  32'd6,         32'd9,         32'd6,         33};

        rst_n   = 1'b0;
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd100;
        b_i     = 32'd7;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'b0, stall_o}, 32'd0);
        chk("reset done", {31'b0, done_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
            idle_check(tbl[i].name, tbl[i].exp);
        end

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 2))
                0:       rop = OP_MULHU;
                1:       rop = OP_DIVU;
                default: rop = OP_REMU;
            endcase
            ra = $urandom;
            rb = (k == 2) ? 32'd0 : ((k % 2 == 1) ? $urandom_range(1, 1000) : $urandom);
            run_op("random", rop, ra, rb, model(rop, ra, rb),
                   ((rop != OP_MULHU) && (rb == 0)) ? 1 : 33);
            idle_check("random", model(rop, ra, rb));
        end

        // Back-to-back with start held: second op launches from IDLE at cycle 34, done at 67.
        run_op("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("b2b_remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        idle_check("b2b", 32'd2);

        // Flush at cycle 10 of a divide, then a fresh divide from cycle 12.
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd100;
        b_i     = 32'd7;
        bad     = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (!stall_o || done_o) bad++;
            @(posedge clk);
            #1;
        end
        chk("flush pre_stall", bad, 0);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush stall_c10", {31'b0, stall_o}, 32'd0);
        chk("flush done_c10", {31'b0, done_o}, 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("flush stall_c11", {31'b0, stall_o}, 32'd0);
        chk("flush done_c11", {31'b0, done_o}, 32'd0);
        @(posedge clk);
        #1;
        run_op("post_flush_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
        idle_check("post_flush", 32'd3);

        // Asynchronous reset at cycle 15 of a mulhu.
        start_i = 1'b1;
        op_i    = OP_MULHU;
        a_i     = 32'hFFFF_FFFF;
        b_i     = 32'hFFFF_FFFF;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset stall", {31'b0, stall_o}, 32'd0);
        chk("midreset done", {31'b0, done_o}, 32'd0);
        chk("midreset result", result_o, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done_o || stall_o) bad++;
        end
        chk("midreset no_done_after", bad, 0);
        @(posedge clk);
        #1;

        // Unsupported op with start held must never stall or complete.
        start_i = 1'b1;
        op_i    = 5'b00000;
        a_i     = 32'd100;
        b_i     = 32'd7;
        bad     = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done_o || stall_o) bad++;
        end
        chk("unsupported ignored", bad, 0);
        start_i = 1'b0;
        @(posedge clk);
        #1;

        chk("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle controller and datapath for the M-extension ops that the decode stage emits on Alu_Control: mulhu (5'b01111), divu (5'b10000) and remu (5'b10001).
- Sits in the execute stage beside the single-cycle ALU.
- While an operation iterates, it holds the EX instruction in place through a stall output to the hazard logic.
- Returns a one-cycle-valid 32-bit result for the writeback path.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  EX holds an MDU instruction (decoded op valid).
- op_i  in  5  Alu_Control code of the EX instruction.
- a_i  in  XLEN  rs1 operand (already forwarded).
- b_i  in  XLEN  rs2 operand (already forwarded).
- flush_i  in  1  EX flush (branch/jump redirect); aborts the operation.
- stall_o  out  1  freeze IF/ID/EX registers this cycle.
- done_o  out  1  result_o valid this cycle (single-cycle pulse).
- result_o  out  XLEN  operation result.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, internal registers 0, done_o=0, result_o=0; stall_o=0 while in reset.
- States:
  - IDLE: waiting. Any op_i other than the three MDU codes with start_i high is ignored: stall_o=0, no state change.
  - CALC: one iteration per clock.
  - DONE: result presented.
- IDLE -> CALC: start_i=1, supported op_i, flush_i=0, and not a divide-by-zero.
  - Latch op and operands; counter=0.
  - Divide: remainder=0, quotient=a_i, divisor=b_i.
  - mulhu: accumulator=0, multiplier=a_i, multiplicand=b_i.
- IDLE -> DONE, fast path: divu/remu with b_i==0. Latch the RISC-V-defined result: divu gives all-ones (32'hFFFFFFFF), remu gives a_i.
- CALC, each cycle:
  - Divide: restoring radix-2 step. Shift {rem,quo} left 1, trial subtract divisor from rem (XLEN+1-bit), keep on no borrow, set quo LSB.
  - mulhu: shift-add step producing the 2*XLEN-bit product.
  - Counter increments each cycle; after XLEN iterations (counter==XLEN-1 on the edge) go to DONE.
- DONE: done_o=1 and result_o valid.
  - divu returns the quotient; remu returns the remainder; mulhu returns product[2*XLEN-1:XLEN].
  - Always returns to IDLE next edge. start_i still high here is the same instruction and must not retrigger.
- result_o is registered and holds its value until the next DONE; only done_o qualifies it.
- stall_o (combinational) = (state==CALC) | (state==IDLE & start_i & supported op & ~flush_i). It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency:
  - Start cycle 0 (IDLE, stall high).
  - CALC cycles 1..XLEN.
  - DONE at cycle XLEN+1 (33).
  - Divide-by-zero fast path: DONE at cycle 1.
- flush_i high in any state: next state IDLE, done_o not asserted, stall_o forced 0 that cycle. Flush has priority over start and completion.
- Reset mid-operation: immediate abort to reset values; no done pulse afterwards.
- Operand changes on a_i/b_i during CALC have no effect (latched at start).

Decomposition:
- Package mdu_pkg: ALU_MULHU/ALU_DIVU/ALU_REMU localparams (5-bit codes above), state enum {IDLE,CALC,DONE}, XLEN default.
- Sub-module mdu_iter_core: pure datapath. It holds the shift/subtract/add registers, with load/step/op-select inputs, and exposes quotient, remainder and product-high.
- mdu_sequencer itself holds the FSM, counter, stall/done logic and result register.

Test Plan:
- divu a=100, b=7, start held until done -> stall_o high cycles 0..32, done_o=1 at cycle 33 with result 14, stall_o=0 at cycle 33, then IDLE.
- remu a=100, b=7 -> result 2 at cycle 33; remu a=32'hFFFFFFFF, b=1 -> 0; divu same operands -> 32'hFFFFFFFF.
- mulhu a=b=32'hFFFFFFFF -> result 32'hFFFFFFFE at cycle 33; a=32'h80000000, b=2 -> 1.
- Divide by zero: divu a=5, b=0 -> done_o at cycle 1, result 32'hFFFFFFFF, stall only cycle 0; remu a=5, b=0 -> 5.
- divu 100/7 with flush_i pulsed at cycle 10 -> IDLE at cycle 11, no done_o, stall_o=0 from cycle 10. A fresh divu 9/3 started at cycle 12 -> result 3 at cycle 45.
- Reset and misc:
  - rst_n low at cycle 15 of mulhu -> outputs zero immediately; after release, no done_o.
  - Unsupported op_i=5'b00000 with start_i -> stall_o=0, no done_o.
  - Back-to-back ops: divu then remu, start_i held continuously -> two done pulses at cycles 33 and 67, with IDLE at cycle 34.
